ahb_manager_seq: RTL

Command sequencer that sits directly upstream of `ahb_manager` and drives its user interface. It accepts one block-transfer command (start address, beat count, size, direction, wrap) and issues the beats to the manager while honouring `o_stall`. Write data is taken from a valid/ready stream. Returned read data is forwarded as an address-tagged stream, and one completion pulse is raised per command.

---
 rtl/ahb_manager_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_manager_seq.sv
// ahb_manager_seq: block-transfer command sequencer that drives the user
// interface of ahb_manager. One command (addr/len/size/dir/wrap) is expanded
// into beats; write data comes from a valid/ready stream and read data is
// returned as an address-tagged stream with a last marker.
module ahb_manager_seq #(
  parameter int DATA_WDT = 32
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  // command
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wr,
  input  logic [31:0]         i_cmd_addr,
  input  logic [15:0]         i_cmd_len,
  input  logic [2:0]          i_cmd_size,
  input  logic                i_cmd_wrap,
  // write-data stream
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [DATA_WDT-1:0] i_wdata,
  // read-data stream (no backpressure)
  output logic                o_rdata_valid,
  output logic [DATA_WDT-1:0] o_rdata,
  output logic [31:0]         o_rdata_addr,
  output logic                o_rdata_last,
  // status
  output logic                o_busy,
  output logic                o_done,
  output logic                o_done_err,
  // manager user interface
  output logic                o_mgr_idle,
  output logic                o_mgr_wr,
  output logic                o_mgr_rd,
  output logic                o_mgr_first_xfer,
  output logic                o_mgr_wrap,
  output logic [31:0]         o_mgr_addr,
  output logic [2:0]          o_mgr_size,
  output logic [15:0]         o_mgr_min_len,
  output logic [DATA_WDT-1:0] o_mgr_wr_data,
  input  logic                i_mgr_stall,
  input  logic                i_mgr_err,
  input  logic [DATA_WDT-1:0] i_mgr_rd_data,
  input  logic [31:0]         i_mgr_rd_data_addr,
  input  logic                i_mgr_rd_data_dav
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_state_next;

  logic                r_wr;
  logic [31:0]         r_addr;
  logic [15:0]         r_len;
  logic [2:0]          r_size;
  logic                r_wrap;
  logic [16:0]         r_iss_ctr;
  logic [16:0]         r_ret_ctr;
  logic                r_first_pend;
  logic                r_err;
  logic                r_rdata_valid;
  logic [DATA_WDT-1:0] r_rdata;
  logic [31:0]         r_rdata_addr;
  logic                r_rdata_last;

  logic w_in_issue, w_active, w_accept, w_abort;
  logic w_present, w_fire, w_dav, w_last_fire, w_last_ret;

  // Beat presentation / fire / return qualifiers.
  always_comb begin
    w_in_issue  = (r_state == S_ISSUE);
    w_active    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    w_accept    = (r_state == S_IDLE) && i_cmd_valid;
    w_abort     = w_active && i_mgr_err;
    // A read beat is always presented; a write beat needs stream data.
    w_present   = w_in_issue && (!r_wr || i_wdata_valid);
    w_fire      = w_present && !i_mgr_stall;
    // Returns that coincide with an abort are dropped with the rest.
    w_dav       = w_active && i_mgr_rd_data_dav && !i_mgr_err;
    w_last_fire = w_fire && (r_iss_ctr == 17'd1);
    w_last_ret  = w_dav && (r_ret_ctr == 17'd1);
  end

  // State register.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) r_state <= S_IDLE;
    else             r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_cmd_valid) w_state_next = (i_cmd_len != 16'd0) ? S_ISSUE : S_DONE;
      S_ISSUE: begin
        if (i_mgr_err)        w_state_next = S_DONE;
        else if (w_last_fire) w_state_next = r_wr ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (i_mgr_err || w_last_ret || (r_ret_ctr == 17'd0)) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Manager handshake drive: idle by default, beat while presented, and
  // BUSY (all low) for a write gap once the burst has started.
  always_comb begin
    o_mgr_idle       = 1'b1;
    o_mgr_rd         = 1'b0;
    o_mgr_wr         = 1'b0;
    o_mgr_first_xfer = 1'b1;
    if (w_in_issue) begin
      if (w_present) begin
        o_mgr_idle       = 1'b0;
        o_mgr_rd         = !r_wr;
        o_mgr_wr         = r_wr;
        o_mgr_first_xfer = r_first_pend;
      end else if (!r_first_pend) begin
        o_mgr_idle       = 1'b0;
        o_mgr_first_xfer = 1'b0;
      end
    end
  end

  // Command capture, issue/return counters and abort flag.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_wrap       <= 1'b0;
      r_iss_ctr    <= '0;
      r_ret_ctr    <= '0;
      r_first_pend <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_wr         <= i_cmd_wr;
      r_addr       <= i_cmd_addr;
      r_len        <= i_cmd_len;
      r_size       <= i_cmd_size;
      r_wrap       <= i_cmd_wrap;
      r_iss_ctr    <= {1'b0, i_cmd_len};
      r_ret_ctr    <= {1'b0, i_cmd_len};
      r_first_pend <= 1'b1;
      r_err        <= 1'b0;
    end else if (w_abort || (r_state == S_DONE)) begin
      // Outstanding work is discarded on abort or completion.
      r_iss_ctr    <= '0;
      r_ret_ctr    <= '0;
      r_first_pend <= 1'b0;
      if (w_abort) r_err <= 1'b1;
    end else begin
      if (w_fire) begin
        r_iss_ctr    <= r_iss_ctr - 17'd1;
        r_first_pend <= 1'b0;
      end
      if (w_dav) r_ret_ctr <= r_ret_ctr - 17'd1;
    end
  end

  // Registered read-data forwarding.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
      r_rdata_addr  <= '0;
      r_rdata_last  <= 1'b0;
    end else begin
      r_rdata_valid <= w_dav;
      r_rdata_last  <= w_last_ret;
      if (w_dav) begin
        r_rdata      <= i_mgr_rd_data;
        r_rdata_addr <= i_mgr_rd_data_addr;
      end
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_done_err    = (r_state == S_DONE) && r_err;
  assign o_wdata_ready = w_in_issue && r_wr && !i_mgr_stall;
  assign o_mgr_wr_data = (w_in_issue && r_wr) ? i_wdata : '0;
  assign o_mgr_addr    = r_addr;
  assign o_mgr_size    = r_size;
  assign o_mgr_min_len = r_len;
  assign o_mgr_wrap    = r_wrap;
  assign o_rdata_valid = r_rdata_valid;
  assign o_rdata       = r_rdata;
  assign o_rdata_addr  = r_rdata_addr;
  assign o_rdata_last  = r_rdata_last;

endmodule
